// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
//   REG_W / DATA_W : register address and data widths
//   arb_state_e    : arbiter FSM encoding (ARB, FORCE)
//   wb_src_e       : source tag shown on wb_src (pipeline / long-latency)
//   wb_entry_t     : one queued long-latency result (address + data)
package wb_port_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_FORCE = 1'b1
  } arb_state_e;

  typedef enum logic {
    SRC_PIPE = 1'b0,
    SRC_LONG = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Writes to r0 are architecturally dropped, so both sources test for it.
  function automatic logic is_reg_zero(input logic [REG_W-1:0] addr);
    return (addr == {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the WB mux / long-latency unit and the write-port arbiter.
//   wb_*     : pipeline WB-stage write request and stall back-pressure
//   l_*      : long-latency result valid/ready handshake
//   rf_*     : registered register-file write port
//   wb_src   : source of the current rf write (0 pipeline, 1 long-latency)
//   pending  : long-latency FIFO occupancy
// Modport slave is the arbiter; master is the surrounding pipeline.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int PEND_W = $clog2(DEPTH) + 1;

  logic              wb_valid;
  logic [REG_W-1:0]  wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_stall;
  logic              l_valid;
  logic              l_ready;
  logic [REG_W-1:0]  l_addr;
  logic [DATA_W-1:0] l_data;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_src;
  logic [PEND_W-1:0] pending;

  modport slave (
    input  wb_valid, wb_addr, wb_data, l_valid, l_addr, l_data,
    output wb_stall, l_ready, rf_we, rf_waddr, rf_wdata, wb_src, pending
  );

  modport master (
    output wb_valid, wb_addr, wb_data, l_valid, l_addr, l_data,
    input  wb_stall, l_ready, rf_we, rf_waddr, rf_wdata, wb_src, pending
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding long-latency results until they get the port.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push/i_entry : enqueue (ignored when full)
//   i_pop          : dequeue head (ignored when empty)
//   o_head         : current head entry
//   o_full/o_empty : status flags
//   o_count        : occupancy 0..DEPTH
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  wb_entry_t                i_entry,
  input  logic                     i_pop,
  output wb_entry_t                o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array: datapath only, contents are don't-care while count is 0.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline WB stage and
// queued long-latency results. Pipeline wins in ARB; a starved FIFO head
// forces one FORCE cycle that stalls the pipeline and writes the head.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : wb_port_arbiter_if.slave (see interface header)
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  wb_port_arbiter_if.slave      bus
);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_grant_pipe;
  logic               w_grant_fifo;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  wb_entry_t          w_in_entry;
  wb_entry_t          w_head;
  logic               r_rf_we;
  logic [REG_W-1:0]   r_rf_waddr;
  logic [DATA_W-1:0]  r_rf_wdata;
  wb_src_e            r_src;

  // r0 results complete the handshake but never occupy a slot.
  assign w_push     = bus.l_valid && !w_full && !is_reg_zero(bus.l_addr);
  assign w_in_entry = '{addr: bus.l_addr, data: bus.l_data};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_entry (w_in_entry),
    .i_pop   (w_grant_fifo),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (bus.pending)
  );

  // Ready depends on occupancy only: a same-cycle pop never lets a full FIFO accept.
  assign bus.l_ready  = !w_full;
  assign bus.wb_stall = (r_state == ST_FORCE);
  assign bus.rf_we    = r_rf_we;
  assign bus.rf_waddr = r_rf_waddr;
  assign bus.rf_wdata = r_rf_wdata;
  assign bus.wb_src   = r_src;

  // Grant selection, next state and starvation counter.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_pipe = 1'b0;
    w_grant_fifo = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (bus.wb_valid && !is_reg_zero(bus.wb_addr)) begin
          w_grant_pipe = 1'b1;
        end else if (!w_empty) begin
          w_grant_fifo = 1'b1;
        end else begin
          w_grant_fifo = 1'b0;
        end
        if (!w_empty && !w_grant_fifo && (r_cnt == CNT_W'(STARVE_LIMIT - 1))) begin
          w_state_nxt = ST_FORCE;
        end else begin
          w_state_nxt = ST_ARB;
        end
      end
      ST_FORCE: begin
        w_grant_fifo = !w_empty;
        w_state_nxt  = ST_ARB;
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
    if (w_empty || w_grant_fifo) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // FSM state and starvation counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_ARB;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered write port; address/data/source hold between grants.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= {REG_W{1'b0}};
      r_rf_wdata <= {DATA_W{1'b0}};
      r_src      <= SRC_PIPE;
    end else begin
      r_rf_we <= w_grant_pipe || w_grant_fifo;
      if (w_grant_pipe) begin
        r_rf_waddr <= bus.wb_addr;
        r_rf_wdata <= bus.wb_data;
        r_src      <= SRC_PIPE;
      end else if (w_grant_fifo) begin
        r_rf_waddr <= w_head.addr;
        r_rf_wdata <= w_head.data;
        r_src      <= SRC_LONG;
      end else begin
        r_rf_waddr <= r_rf_waddr;
        r_rf_wdata <= r_rf_wdata;
        r_src      <= r_src;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=4, STARVE_LIMIT=8).
module tb_wb_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  wb_port_arbiter_if #(.DEPTH(4)) bus ();

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .CNT_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs set beforehand are captured, outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'h0;
    bus.l_valid  = 1'b0; bus.l_addr  = 5'd0; bus.l_data  = 32'h0;
  endtask

  int          first_stall;
  int          stall_cnt;
  logic        we_k9, src_k9, src_k10, pend_k8, pend_k9;
  logic [4:0]  addr_k9, addr_k10;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    step(); step();
    // Reset state
    check("rst_rf_we",    {31'd0, bus.rf_we},    32'd0);
    check("rst_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    check("rst_rf_wdata", bus.rf_wdata,          32'd0);
    check("rst_wb_src",   {31'd0, bus.wb_src},   32'd0);
    check("rst_wb_stall", {31'd0, bus.wb_stall}, 32'd0);
    check("rst_pending",  {29'd0, bus.pending},  32'd0);
    check("rst_l_ready",  {31'd0, bus.l_ready},  32'd1);
    rst_n = 1'b1;
    step();

    // Pipeline-only write
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
    step();
    check("pipe_we",    {31'd0, bus.rf_we},    32'd1);
    check("pipe_waddr", {27'd0, bus.rf_waddr}, 32'd5);
    check("pipe_wdata", bus.rf_wdata,          32'h1234);
    check("pipe_src",   {31'd0, bus.wb_src},   32'd0);
    idle_inputs();
    step();
    check("pipe_we_drop", {31'd0, bus.rf_we}, 32'd0);

    // Idle port: accept at t, write visible at t+2
    bus.l_valid = 1'b1; bus.l_addr = 5'd9; bus.l_data = 32'hBEEF;
    step();
    idle_inputs();
    check("idle_t1_we",      {31'd0, bus.rf_we},   32'd0);
    check("idle_t1_pending", {29'd0, bus.pending}, 32'd1);
    step();
    check("idle_t2_we",      {31'd0, bus.rf_we},    32'd1);
    check("idle_t2_waddr",   {27'd0, bus.rf_waddr}, 32'd9);
    check("idle_t2_wdata",   bus.rf_wdata,          32'hBEEF);
    check("idle_t2_src",     {31'd0, bus.wb_src},   32'd1);
    check("idle_t2_pending", {29'd0, bus.pending},  32'd0);
    step();
    check("idle_t3_we", {31'd0, bus.rf_we}, 32'd0);

    // Starvation: head r3 waits while pipeline writes r7 every cycle.
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h70;
    bus.l_valid  = 1'b1; bus.l_addr  = 5'd3; bus.l_data  = 32'h3333;
    step();
    bus.l_valid = 1'b0;
    first_stall = -1; stall_cnt = 0;
    we_k9 = 1'b0; src_k9 = 1'b0; src_k10 = 1'b1; pend_k8 = 1'b0; pend_k9 = 1'b1;
    addr_k9 = 5'd0; addr_k10 = 5'd0;
    for (int k = 0; k < 12; k++) begin
      if (bus.wb_stall) begin
        stall_cnt++;
        if (first_stall < 0) first_stall = k;
      end
      if (k == 8) pend_k8 = (bus.pending == 3'd1);
      if (k == 9) begin
        we_k9 = bus.rf_we; addr_k9 = bus.rf_waddr; src_k9 = bus.wb_src;
        pend_k9 = (bus.pending == 3'd0);
      end
      if (k == 10) begin addr_k10 = bus.rf_waddr; src_k10 = bus.wb_src; end
      step();
    end
    check("starve_first_stall", first_stall, 32'd8);
    check("starve_stall_cnt",   stall_cnt,   32'd1);
    check("starve_pend_wait",   {31'd0, pend_k8},  32'd1);
    check("starve_forced_we",   {31'd0, we_k9},    32'd1);
    check("starve_forced_addr", {27'd0, addr_k9},  32'd3);
    check("starve_forced_src",  {31'd0, src_k9},   32'd1);
    check("starve_pend_empty",  {31'd0, pend_k9},  32'd1);
    check("starve_resume_addr", {27'd0, addr_k10}, 32'd7);
    check("starve_resume_src",  {31'd0, src_k10},  32'd0);
    idle_inputs();
    step();

    // Full FIFO with pipeline busy
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h70;
    bus.l_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.l_addr = 5'(10 + i); bus.l_data = 32'hA0 + 32'(i);
      step();
    end
    check("full_pending", {29'd0, bus.pending}, 32'd4);
    check("full_l_ready", {31'd0, bus.l_ready}, 32'd0);
    bus.l_addr = 5'd14; bus.l_data = 32'hA4;
    step();
    check("full_held_pending", {29'd0, bus.pending}, 32'd4);
    check("full_held_l_ready", {31'd0, bus.l_ready}, 32'd0);
    bus.wb_valid = 1'b0;
    step();
    check("pop1_pending", {29'd0, bus.pending},  32'd3);
    check("pop1_l_ready", {31'd0, bus.l_ready},  32'd1);
    check("pop1_waddr",   {27'd0, bus.rf_waddr}, 32'd10);
    check("pop1_src",     {31'd0, bus.wb_src},   32'd1);
    step();
    check("pushpop_pending", {29'd0, bus.pending},  32'd3);
    check("pushpop_waddr",   {27'd0, bus.rf_waddr}, 32'd11);
    bus.l_valid = 1'b0;
    step();
    check("drain_waddr_12", {27'd0, bus.rf_waddr}, 32'd12);
    step();
    check("drain_waddr_13", {27'd0, bus.rf_waddr}, 32'd13);
    step();
    check("drain_waddr_14", {27'd0, bus.rf_waddr}, 32'd14);
    check("drain_wdata_14", bus.rf_wdata,          32'hA4);
    check("drain_pending",  {29'd0, bus.pending},  32'd0);
    step();
    check("drain_we_off", {31'd0, bus.rf_we}, 32'd0);

    // Register 0 on both sources
    bus.l_valid = 1'b1; bus.l_addr = 5'd0; bus.l_data = 32'hDEAD;
    step();
    check("l_r0_l_ready_seen", {31'd0, bus.l_ready}, 32'd1);
    check("l_r0_pending",      {29'd0, bus.pending}, 32'd0);
    check("l_r0_we_t1",        {31'd0, bus.rf_we},   32'd0);
    bus.l_valid = 1'b0;
    step();
    check("l_r0_we_t2", {31'd0, bus.rf_we}, 32'd0);
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd7;  bus.wb_data = 32'h77;
    bus.l_valid  = 1'b1; bus.l_addr  = 5'd20; bus.l_data  = 32'h2020;
    step();
    check("r0_setup_waddr",   {27'd0, bus.rf_waddr}, 32'd7);
    check("r0_setup_pending", {29'd0, bus.pending},  32'd1);
    bus.wb_addr = 5'd0; bus.wb_data = 32'h55; bus.l_valid = 1'b0;
    step();
    check("wb_r0_we",      {31'd0, bus.rf_we},    32'd1);
    check("wb_r0_waddr",   {27'd0, bus.rf_waddr}, 32'd20);
    check("wb_r0_wdata",   bus.rf_wdata,          32'h2020);
    check("wb_r0_src",     {31'd0, bus.wb_src},   32'd1);
    check("wb_r0_pending", {29'd0, bus.pending},  32'd0);
    idle_inputs();
    step();
    check("wb_r0_we_off", {31'd0, bus.rf_we}, 32'd0);

    // Asynchronous reset mid-burst with three entries queued
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h70;
    bus.l_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.l_addr = 5'(1 + i); bus.l_data = 32'hC0 + 32'(i);
      step();
    end
    check("pre_rst_pending", {29'd0, bus.pending}, 32'd3);
    check("pre_rst_we",      {31'd0, bus.rf_we},   32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we",      {31'd0, bus.rf_we},    32'd0);
    check("arst_pending", {29'd0, bus.pending},  32'd0);
    check("arst_l_ready", {31'd0, bus.l_ready},  32'd1);
    check("arst_stall",   {31'd0, bus.wb_stall}, 32'd0);
    check("arst_waddr",   {27'd0, bus.rf_waddr}, 32'd0);
    idle_inputs();
    step();
    rst_n = 1'b1;
    step(); step();
    check("post_rst_we",      {31'd0, bus.rf_we},   32'd0);
    check("post_rst_pending", {29'd0, bus.pending}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
